pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter MD_LAT, default 32: multi-cycle mul/div latency in cycles, legal range 2..63.
REQ-002 clk  in  1  clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 ID_RsAddr  in  5  rs field of the instruction in decode.
REQ-005 ID_RtAddr  in  5  rt field of the instruction in decode.
REQ-006 ID_UsesRt  in  1  decode instruction reads rt as a source.
REQ-007 EX_MemRead  in  1  instruction in EX is a load.
REQ-008 EX_RtAddr  in  5  load destination held in the ID/EX register.
REQ-009 EX_MdStart  in  1  instruction in EX is a mul/div; single-cycle qualifier.
REQ-010 BranchTaken  in  1  branch/jump resolved taken in EX.
REQ-011 PC_En  out  1  PC update enable.
REQ-012 IFID_En, IFID_Clr  out  1 each  IF/ID register enable and synchronous clear.
REQ-013 IDEX_En, IDEX_Clr  out  1 each  ID/EX register enable and synchronous clear.
REQ-014 MdBusy  out  1  high while in MD_WAIT.
REQ-015 MdDone  out  1  registered one-cycle pulse on the final MD_WAIT cycle.
REQ-016 StallCnt  out  16  count of stall cycles, saturating.

Function
REQ-017 States: RUN, MD_WAIT; 6-bit down-counter MdCnt; StallCnt; MdDone register.
REQ-018 Control outputs are combinational from state and inputs; all other outputs are registered.
REQ-019 LoadUse = EX_MemRead & EX_RtAddr!=0 & (EX_RtAddr==ID_RsAddr | (ID_UsesRt & EX_RtAddr==ID_RtAddr)).
REQ-020 RUN, default: PC_En=1, IFID_En=1, IDEX_En=1, both Clr=0.
REQ-021 RUN, BranchTaken=1 (highest priority): PC_En=1, IFID_Clr=1, IDEX_Clr=1; LoadUse and EX_MdStart are ignored that cycle.
REQ-022 RUN, LoadUse=1, no branch: PC_En=0, IFID_En=0, IDEX_Clr=1 (bubble); exactly one stall per hazard; the bubble clears the condition on the next cycle.
REQ-023 RUN, EX_MdStart=1, no branch: next state MD_WAIT, MdCnt<=MD_LAT-1; the current cycle stalls as in REQ-024.
REQ-024 MD_WAIT: PC_En=0, IFID_En=0, IDEX_En=0, both Clr=0 (hold); MdCnt decrements each cycle.
REQ-025 MD_WAIT with MdCnt==1: MdDone<=1 on the next edge, next state RUN; the pipeline advances on the first RUN cycle.
REQ-026 BranchTaken, LoadUse and EX_MdStart are ignored in MD_WAIT.
REQ-027 The total MD stall is exactly MD_LAT cycles, counted from the EX_MdStart cycle.
REQ-028 Clr has priority over En at each register; an output pair with Clr=1 drives En=1.
REQ-029 StallCnt increments each cycle PC_En=0 and holds at 16'hFFFF.

Reset
REQ-030 rst low asynchronously forces: state=RUN, MdCnt=0, MdDone=0, StallCnt=0.
REQ-031 During reset, combinational outputs follow RUN decode.
REQ-032 Reset mid-MD_WAIT aborts the wait; no MdDone pulse is produced.

Verification
REQ-033 EX_MemRead=1, EX_RtAddr=8, ID_RsAddr=8 -> one cycle PC_En=0, IFID_En=0, IDEX_Clr=1; next cycle all enables=1; StallCnt=1.
REQ-034 Same as REQ-033 with EX_RtAddr=0 -> no stall; StallCnt stays 0.
REQ-035 ID_RtAddr match with ID_UsesRt=0 -> no stall; with ID_UsesRt=1 -> one bubble.
REQ-036 LoadUse and BranchTaken in the same cycle -> IFID_Clr=1, IDEX_Clr=1, PC_En=1; no stall counted.
REQ-037 MD_LAT=4, EX_MdStart pulse -> PC_En=0 for 4 cycles, MdBusy high 3 cycles, one MdDone pulse, then RUN; StallCnt=4.
REQ-038 rst asserted on the second MD_WAIT cycle -> immediately state=RUN, MdBusy=0, StallCnt=0, no MdDone pulse.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, taken-branch flushes and a
// multi-cycle mul/div wait that freezes the front of the pipeline.
module pipe_hazard_ctrl #(
    parameter int MD_LAT = 32  // mul/div latency in cycles, legal 2..63
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ID_RsAddr,
    input  logic [4:0]  ID_RtAddr,
    input  logic        ID_UsesRt,
    input  logic        EX_MemRead,
    input  logic [4:0]  EX_RtAddr,
    input  logic        EX_MdStart,
    input  logic        BranchTaken,
    output logic        PC_En,
    output logic        IFID_En,
    output logic        IFID_Clr,
    output logic        IDEX_En,
    output logic        IDEX_Clr,
    output logic        MdBusy,
    output logic        MdDone,
    output logic [15:0] StallCnt
);

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } mdState_t;

    // The EX_MdStart cycle is the first stall cycle, so the wait state covers
    // the remaining MD_LAT-1 cycles.
    localparam logic [5:0] MdInit = 6'(MD_LAT - 1);

    mdState_t   state;
    mdState_t   nextState;
    logic [5:0] mdCnt;
    logic       loadUse;
    logic       mdLast;
    logic       mdLaunch;

    assign loadUse = EX_MemRead && (EX_RtAddr != 5'd0) &&
                     ((EX_RtAddr == ID_RsAddr) ||
                      (ID_UsesRt && (EX_RtAddr == ID_RtAddr)));

    assign mdLaunch = (state == RUN) && !BranchTaken && EX_MdStart;
    assign mdLast   = (state == MD_WAIT) && (mdCnt <= 6'd1);
    assign MdBusy   = (state == MD_WAIT);

    // NOTE: every clocked process uses non-blocking assignments so that all
    // registers sample the values from before the edge, independent of order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            state <= nextState;
        end
    end

    // NOTE: each combinational process assigns defaults first so that no path
    // leaves an output unassigned and no latch is inferred.
    always_comb begin
        nextState = state;
        unique case (state)
            RUN:     if (mdLaunch) nextState = MD_WAIT;
            MD_WAIT: if (mdLast)   nextState = RUN;
            default: nextState = RUN;
        endcase
    end

    // Clr always comes with En=1 so the clear wins at the pipeline register.
    always_comb begin
        PC_En    = 1'b1;
        IFID_En  = 1'b1;
        IFID_Clr = 1'b0;
        IDEX_En  = 1'b1;
        IDEX_Clr = 1'b0;
        unique case (state)
            RUN: begin
                if (BranchTaken) begin
                    IFID_Clr = 1'b1;
                    IDEX_Clr = 1'b1;
                end else if (EX_MdStart) begin
                    PC_En   = 1'b0;
                    IFID_En = 1'b0;
                    IDEX_En = 1'b0;
                end else if (loadUse) begin
                    PC_En    = 1'b0;
                    IFID_En  = 1'b0;
                    IDEX_Clr = 1'b1;
                end
            end
            MD_WAIT: begin
                PC_En   = 1'b0;
                IFID_En = 1'b0;
                IDEX_En = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mdCnt <= 6'd0;
        end else if (mdLaunch) begin
            mdCnt <= MdInit;
        end else if (state == MD_WAIT) begin
            mdCnt <= mdCnt - 6'd1;
        end
    end

    // Registered pulse, visible on the first RUN cycle after the wait.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            MdDone <= 1'b0;
        end else begin
            MdDone <= mdLast;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            StallCnt <= 16'd0;
        end else if (!PC_En && (StallCnt != 16'hFFFF)) begin
            StallCnt <= StallCnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl with MD_LAT=4: directed vectors push
// hand-computed expectations; a negedge monitor pops and compares them.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ID_RsAddr;
    logic [4:0]  ID_RtAddr;
    logic        ID_UsesRt;
    logic        EX_MemRead;
    logic [4:0]  EX_RtAddr;
    logic        EX_MdStart;
    logic        BranchTaken;
    logic        PC_En;
    logic        IFID_En;
    logic        IFID_Clr;
    logic        IDEX_En;
    logic        IDEX_Clr;
    logic        MdBusy;
    logic        MdDone;
    logic [15:0] StallCnt;

    pipe_hazard_ctrl #(.MD_LAT(4)) dut (
        .clk(clk), .rst(rst),
        .ID_RsAddr(ID_RsAddr), .ID_RtAddr(ID_RtAddr), .ID_UsesRt(ID_UsesRt),
        .EX_MemRead(EX_MemRead), .EX_RtAddr(EX_RtAddr),
        .EX_MdStart(EX_MdStart), .BranchTaken(BranchTaken),
        .PC_En(PC_En), .IFID_En(IFID_En), .IFID_Clr(IFID_Clr),
        .IDEX_En(IDEX_En), .IDEX_Clr(IDEX_Clr),
        .MdBusy(MdBusy), .MdDone(MdDone), .StallCnt(StallCnt)
    );

    always #5 clk = ~clk;

    // ctrl packs {PC_En, IFID_En, IFID_Clr, IDEX_En, IDEX_Clr}
    typedef struct {
        string       name;
        logic [4:0]  ctrl;
        logic        busy;
        logic        done;
        logic [15:0] stall;
    } exp_t;

    localparam logic [4:0] CRun   = 5'b11010;
    localparam logic [4:0] CBub   = 5'b00011;
    localparam logic [4:0] CFlush = 5'b11111;
    localparam logic [4:0] CHold  = 5'b00000;

    exp_t expQ[$];
    exp_t monE;
    int   vectors = 0;
    int   miscompares = 0;
    logic stimDone = 1'b0;
    logic checkDone = 1'b0;
    int   drainCycles = 0;

    task automatic apply(input string name, input logic r,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic usesRt, input logic memRead,
                         input logic [4:0] exRt, input logic mdStart,
                         input logic br, input logic [4:0] ctrl,
                         input logic busy, input logic done,
                         input logic [15:0] stall);
        exp_t e;
        @(posedge clk);
        #1;
        rst         = r;
        ID_RsAddr   = rs;
        ID_RtAddr   = rt;
        ID_UsesRt   = usesRt;
        EX_MemRead  = memRead;
        EX_RtAddr   = exRt;
        EX_MdStart  = mdStart;
        BranchTaken = br;
        e.name  = name;
        e.ctrl  = ctrl;
        e.busy  = busy;
        e.done  = done;
        e.stall = stall;
        expQ.push_back(e);
    endtask

    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            monE = expQ.pop_front();
            vectors++;
            if ({PC_En, IFID_En, IFID_Clr, IDEX_En, IDEX_Clr} !== monE.ctrl ||
                MdBusy !== monE.busy || MdDone !== monE.done ||
                StallCnt !== monE.stall) begin
                miscompares++;
                $display("FAIL %s: got ctrl=%b busy=%b done=%b stall=%0d, expected ctrl=%b busy=%b done=%b stall=%0d",
                         monE.name, {PC_En, IFID_En, IFID_Clr, IDEX_En, IDEX_Clr},
                         MdBusy, MdDone, StallCnt, monE.ctrl, monE.busy,
                         monE.done, monE.stall);
            end
        end else if (stimDone && !checkDone) begin
            checkDone = 1'b1;
        end
        if (stimDone && !checkDone) begin
            drainCycles++;
            if (drainCycles > 8) begin
                vectors++;
                miscompares++;
                $display("FAIL drain: got %0d pending expectations, expected 0", expQ.size());
                checkDone = 1'b1;
            end
        end
    end

    initial begin
        rst = 1'b0;
        {ID_RsAddr, ID_RtAddr, ID_UsesRt, EX_MemRead} = '0;
        {EX_RtAddr, EX_MdStart, BranchTaken} = '0;

        //     name            rst rs  rt  uRt mRd exRt md br  ctrl    busy done stall
        apply("reset_idle",    0, 0,  0,  0,  0,  0,  0, 0, CRun,   0, 0, 16'd0);
        apply("reset_hazard",  0, 8,  0,  0,  1,  8,  0, 0, CBub,   0, 0, 16'd0);
        apply("run_idle",      1, 0,  0,  0,  0,  0,  0, 0, CRun,   0, 0, 16'd0);
        apply("loaduse_rs",    1, 8,  0,  0,  1,  8,  0, 0, CBub,   0, 0, 16'd0);
        apply("after_bubble",  1, 8,  0,  0,  0,  8,  0, 0, CRun,   0, 0, 16'd1);
        apply("ex_rt_zero",    1, 0,  0,  0,  1,  0,  0, 0, CRun,   0, 0, 16'd1);
        apply("ex_rt_zero_rt", 1, 0,  0,  1,  1,  0,  0, 0, CRun,   0, 0, 16'd1);
        apply("rt_unused",     1, 3,  9,  0,  1,  9,  0, 0, CRun,   0, 0, 16'd1);
        apply("rt_used",       1, 3,  9,  1,  1,  9,  0, 0, CBub,   0, 0, 16'd1);
        apply("after_rt",      1, 0,  0,  0,  0,  0,  0, 0, CRun,   0, 0, 16'd2);
        apply("branch_lduse",  1, 8,  0,  0,  1,  8,  0, 1, CFlush, 0, 0, 16'd2);
        apply("branch_only",   1, 0,  0,  0,  0,  0,  0, 1, CFlush, 0, 0, 16'd2);
        apply("idle_pre_md",   1, 0,  0,  0,  0,  0,  0, 0, CRun,   0, 0, 16'd2);
        apply("md_start",      1, 0,  0,  0,  0,  0,  1, 0, CHold,  0, 0, 16'd2);
        apply("md_wait1",      1, 0,  0,  0,  0,  0,  0, 0, CHold,  1, 0, 16'd3);
        apply("md_wait2_ign",  1, 8,  0,  0,  1,  8,  0, 1, CHold,  1, 0, 16'd4);
        apply("md_wait3_ign",  1, 0,  0,  0,  0,  0,  1, 0, CHold,  1, 0, 16'd5);
        apply("md_done",       1, 0,  0,  0,  0,  0,  0, 0, CRun,   0, 1, 16'd6);
        apply("md_after",      1, 0,  0,  0,  0,  0,  0, 0, CRun,   0, 0, 16'd6);
        apply("md2_start",     1, 0,  0,  0,  0,  0,  1, 0, CHold,  0, 0, 16'd6);
        apply("md2_wait1",     1, 0,  0,  0,  0,  0,  0, 0, CHold,  1, 0, 16'd7);
        apply("md2_rst",       0, 0,  0,  0,  0,  0,  0, 0, CRun,   0, 0, 16'd0);
        apply("md2_rst_hold",  0, 0,  0,  0,  0,  0,  0, 0, CRun,   0, 0, 16'd0);
        apply("md2_release",   1, 0,  0,  0,  0,  0,  0, 0, CRun,   0, 0, 16'd0);
        apply("md2_no_done",   1, 0,  0,  0,  0,  0,  0, 0, CRun,   0, 0, 16'd0);

        // Hold a load-use hazard long enough to drive StallCnt into saturation.
        apply("sat_start",     1, 8,  0,  0,  1,  8,  0, 0, CBub,   0, 0, 16'd0);
        repeat (65533) @(posedge clk);
        apply("sat_m1",        1, 8,  0,  0,  1,  8,  0, 0, CBub,   0, 0, 16'd65534);
        apply("sat_max",       1, 8,  0,  0,  1,  8,  0, 0, CBub,   0, 0, 16'hFFFF);
        apply("sat_hold",      1, 8,  0,  0,  1,  8,  0, 0, CBub,   0, 0, 16'hFFFF);
        apply("sat_idle",      1, 0,  0,  0,  0,  0,  0, 0, CRun,   0, 0, 16'hFFFF);

        stimDone = 1'b1;
        wait (checkDone);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
